// File: rtl/hazard_pkg.sv
// Shared types and sizing helpers for the RV32I forwarding / hazard control slice.
package hazard_pkg;

   localparam int RA_W_DEFAULT = 5;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      WB
   } mc_state_t;

   // A zero-width select is never useful, so a single-stage pipe still gets one bit.
   function automatic int fwd_sel_w(input int num_stages);
      int w;
      w = $clog2(num_stages + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_mc_scoreboard.sv
// Tracks the single outstanding multi-cycle op: destination, remaining latency,
// and the one-cycle writeback slot.
module mc_scoreboard
   import hazard_pkg::*;
#(
   parameter int RA_W  = RA_W_DEFAULT,
   parameter int LAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mc_issue,
   input  logic [RA_W-1:0]  mc_rd,
   input  logic [LAT_W-1:0] mc_latency,
   output mc_state_t        state,
   output logic [RA_W-1:0]  pend_rd,
   output logic             mc_busy,
   output logic             mc_wb_valid
);

   mc_state_t        state_next;
   logic [RA_W-1:0]  pend_rd_next;
   logic [LAT_W-1:0] countdown, countdown_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend_rd   <= '0;
         countdown <= '0;
      end else begin
         state     <= state_next;
         pend_rd   <= pend_rd_next;
         countdown <= countdown_next;
      end
   end

   // The issue cycle counts as the first latency cycle, so WB lands on cycle
   // 'latency' after issue; latency 1 still spends one cycle in BUSY.
   always_comb begin
      state_next     = state;
      pend_rd_next   = pend_rd;
      countdown_next = countdown;
      mc_busy        = 1'b0;
      mc_wb_valid    = 1'b0;
      case (state)
         IDLE: begin
            if (mc_issue) begin
               state_next     = BUSY;
               pend_rd_next   = mc_rd;
               countdown_next = (mc_latency == '0) ? LAT_W'(1) : mc_latency;
            end
         end
         BUSY: begin
            mc_busy        = 1'b1;
            countdown_next = countdown - 1'b1;
            if (countdown <= LAT_W'(2)) state_next = WB;
         end
         WB: begin
            mc_busy     = 1'b1;
            mc_wb_valid = 1'b1;
            if (mc_issue) begin
               state_next     = BUSY;
               pend_rd_next   = mc_rd;
               countdown_next = (mc_latency == '0) ? LAT_W'(1) : mc_latency;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   a_no_issue_while_busy: assert property (@(posedge clk) disable iff (rst)
      !(mc_issue && state == BUSY));

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX operand forwarding selects, load-use / multi-cycle hazard stall, and a
// saturating stall-cycle counter for the RV32I pipeline.
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 2,
   parameter int RA_W       = RA_W_DEFAULT,
   parameter int LAT_W      = 4,
   parameter int CNT_W      = 32
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_SRC*RA_W-1:0]                  id_ex_rs,
   input  logic [NUM_STAGES*RA_W-1:0]               stage_rd,
   input  logic [NUM_STAGES-1:0]                    stage_regwrite,
   input  logic [NUM_SRC*RA_W-1:0]                  if_id_rs,
   input  logic [NUM_SRC-1:0]                       if_id_rs_used,
   input  logic [RA_W-1:0]                          if_id_rd,
   input  logic                                     if_id_regwrite,
   input  logic                                     if_id_is_mc,
   input  logic [RA_W-1:0]                          id_ex_rd,
   input  logic                                     id_ex_memread,
   input  logic                                     mc_issue,
   input  logic [RA_W-1:0]                          mc_rd,
   input  logic [LAT_W-1:0]                         mc_latency,
   output logic [NUM_SRC*fwd_sel_w(NUM_STAGES)-1:0] forward_sel,
   output logic                                     stall,
   output logic                                     flush_id_ex,
   output logic                                     mc_busy,
   output logic                                     mc_wb_valid,
   output logic [CNT_W-1:0]                         stall_cycles
);

   localparam int SEL_W = fwd_sel_w(NUM_STAGES);

   mc_state_t        mc_state;
   logic [RA_W-1:0]  pend_rd;
   logic             sb_busy, sb_wb_valid;
   logic             load_use, raw_hit, waw_hit, struct_hit, mc_hazard, stall_raw;
   logic [CNT_W-1:0] stall_cnt;

   mc_scoreboard #(.RA_W(RA_W), .LAT_W(LAT_W)) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .mc_issue    (mc_issue),
      .mc_rd       (mc_rd),
      .mc_latency  (mc_latency),
      .state       (mc_state),
      .pend_rd     (pend_rd),
      .mc_busy     (sb_busy),
      .mc_wb_valid (sb_wb_valid)
   );

   // Walk from the farthest stage inward so the nearest matching stage wins.
   for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
      logic [RA_W-1:0]  rs;
      logic [SEL_W-1:0] sel;
      assign rs = id_ex_rs[s*RA_W +: RA_W];
      always_comb begin
         sel = '0;
         for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stage_regwrite[k] && stage_rd[k*RA_W +: RA_W] != '0 &&
                stage_rd[k*RA_W +: RA_W] == rs)
               sel = SEL_W'(k + 1);
         end
      end
      assign forward_sel[s*SEL_W +: SEL_W] = rst ? '0 : sel;
   end

   always_comb begin
      load_use = 1'b0;
      raw_hit  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (if_id_rs_used[i] && if_id_rs[i*RA_W +: RA_W] == id_ex_rd) load_use = 1'b1;
         if (if_id_rs_used[i] && if_id_rs[i*RA_W +: RA_W] == pend_rd)  raw_hit  = 1'b1;
      end
      load_use   = load_use && id_ex_memread && (id_ex_rd != '0);
      raw_hit    = raw_hit && (pend_rd != '0);
      waw_hit    = if_id_regwrite && (if_id_rd == pend_rd) && (pend_rd != '0);
      struct_hit = if_id_is_mc && (mc_state == BUSY);
      mc_hazard  = (mc_state != IDLE) && (raw_hit || waw_hit || struct_hit);
      stall_raw  = load_use || mc_hazard;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall_raw && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
   end

   // Every output is held low while reset is asserted, including mid-op state.
   assign stall        = stall_raw && !rst;
   assign flush_id_ex  = stall;
   assign mc_busy      = sb_busy && !rst;
   assign mc_wb_valid  = sb_wb_valid && !rst;
   assign stall_cycles = rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: table-driven forwarding/load-use
// vectors plus hand-written multi-cycle scoreboard sequences, built with CNT_W=4.
module tb_hazard_forward_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  id_ex_rs = '0;
   logic [9:0]  stage_rd = '0;
   logic [1:0]  stage_regwrite = '0;
   logic [9:0]  if_id_rs = '0;
   logic [1:0]  if_id_rs_used = '0;
   logic [4:0]  if_id_rd = '0;
   logic        if_id_regwrite = 1'b0;
   logic        if_id_is_mc = 1'b0;
   logic [4:0]  id_ex_rd = '0;
   logic        id_ex_memread = 1'b0;
   logic        mc_issue = 1'b0;
   logic [4:0]  mc_rd = '0;
   logic [3:0]  mc_latency = '0;
   logic [3:0]  forward_sel;
   logic        stall, flush_id_ex, mc_busy, mc_wb_valid;
   logic [3:0]  stall_cycles;

   always #5 clk = ~clk;

   hazard_forward_ctrl #(
      .NUM_SRC(2), .NUM_STAGES(2), .RA_W(5), .LAT_W(4), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .id_ex_rs(id_ex_rs), .stage_rd(stage_rd),
      .stage_regwrite(stage_regwrite), .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
      .if_id_rd(if_id_rd), .if_id_regwrite(if_id_regwrite), .if_id_is_mc(if_id_is_mc),
      .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .mc_issue(mc_issue),
      .mc_rd(mc_rd), .mc_latency(mc_latency), .forward_sel(forward_sel), .stall(stall),
      .flush_id_ex(flush_id_ex), .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid),
      .stall_cycles(stall_cycles)
   );

   typedef struct {
      logic       rst;
      logic [9:0] id_ex_rs, stage_rd, if_id_rs;
      logic [1:0] stage_regwrite, if_id_rs_used;
      logic [4:0] if_id_rd, id_ex_rd, mc_rd;
      logic       if_id_regwrite, if_id_is_mc, id_ex_memread, mc_issue;
      logic [3:0] mc_latency;
   } stim_t;

   typedef struct {
      logic [3:0] fsel;
      logic       stall, busy, wbv;
      logic [3:0] cnt;
   } exp_t;

   typedef struct {
      logic [4:0] rs1, rs2, rd0, rd1;
      logic [1:0] rw;
      logic [4:0] idr1, idr2;
      logic [1:0] used;
      logic [4:0] exrd;
      logic       memrd;
      logic [1:0] sel1, sel2;
      logic       stall;
   } vec_t;

   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    exp_cnt  = 0;
   vec_t  tbl[10];
   stim_t s;

   function automatic stim_t quiet();
      stim_t q;
      q.rst = 1'b0;           q.id_ex_rs = '0;       q.stage_rd = '0;
      q.if_id_rs = '0;        q.stage_regwrite = '0; q.if_id_rs_used = '0;
      q.if_id_rd = '0;        q.id_ex_rd = '0;       q.mc_rd = '0;
      q.if_id_regwrite = 1'b0; q.if_id_is_mc = 1'b0; q.id_ex_memread = 1'b0;
      q.mc_issue = 1'b0;      q.mc_latency = '0;
      return q;
   endfunction

   function automatic exp_t ex(input logic [3:0] fsel, input logic st, input logic busy,
                               input logic wbv);
      exp_t e;
      e.fsel = fsel; e.stall = st; e.busy = busy; e.wbv = wbv; e.cnt = '0;
      return e;
   endfunction

   task automatic chk(input string tag, input string field, input logic [31:0] act,
                      input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
      end
   endtask

   // The expected stall count seen in a cycle reflects only earlier stall cycles.
   task automatic applyStimulus(input stim_t st, input exp_t e);
      @(negedge clk);
      rst = st.rst; id_ex_rs = st.id_ex_rs; stage_rd = st.stage_rd;
      stage_regwrite = st.stage_regwrite; if_id_rs = st.if_id_rs;
      if_id_rs_used = st.if_id_rs_used; if_id_rd = st.if_id_rd;
      if_id_regwrite = st.if_id_regwrite; if_id_is_mc = st.if_id_is_mc;
      id_ex_rd = st.id_ex_rd; id_ex_memread = st.id_ex_memread;
      mc_issue = st.mc_issue; mc_rd = st.mc_rd; mc_latency = st.mc_latency;
      e.cnt = st.rst ? 4'd0 : 4'(exp_cnt);
      exp_q.push_back(e);
      if (st.rst) exp_cnt = 0;
      else if (e.stall && exp_cnt != 15) exp_cnt++;
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      #2;
      if (exp_q.size() == 0) begin
         chk(tag, "queue_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, "forward_sel",  32'(forward_sel),  32'(e.fsel));
         chk(tag, "stall",        32'(stall),        32'(e.stall));
         chk(tag, "flush_id_ex",  32'(flush_id_ex),  32'(e.stall));
         chk(tag, "mc_busy",      32'(mc_busy),      32'(e.busy));
         chk(tag, "mc_wb_valid",  32'(mc_wb_valid),  32'(e.wbv));
         chk(tag, "stall_cycles", 32'(stall_cycles), 32'(e.cnt));
      end
   endtask

   task automatic step(input stim_t st, input exp_t e, input string tag);
      applyStimulus(st, e);
      checkOutput(tag);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //          rs1 rs2 rd0 rd1 rw    idr1 idr2 used   exrd memrd sel1 sel2 stall
      tbl[0] = '{5'd5, 5'd5, 5'd5, 5'd5, 2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd1, 2'd1, 1'b0};
      tbl[1] = '{5'd5, 5'd5, 5'd5, 5'd5, 2'b10, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd2, 2'd2, 1'b0};
      tbl[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0};
      tbl[3] = '{5'd3, 5'd4, 5'd4, 5'd3, 2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd2, 2'd1, 1'b0};
      tbl[4] = '{5'd6, 5'd6, 5'd6, 5'd6, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0};
      tbl[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd7, 5'd0, 2'b01, 5'd7, 1'b1, 2'd0, 2'd0, 1'b1};
      tbl[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd7, 2'b01, 5'd7, 1'b1, 2'd0, 2'd0, 1'b0};
      tbl[7] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 2'd0, 2'd0, 1'b0};
      tbl[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd7, 5'd0, 2'b01, 5'd7, 1'b0, 2'd0, 2'd0, 1'b0};
      tbl[9] = '{5'd2, 5'd9, 5'd2, 5'd0, 2'b11, 5'd0, 5'd7, 2'b10, 5'd7, 1'b1, 2'd1, 2'd0, 1'b1};

      // Reset with hazard-causing inputs present: every output must stay low.
      s = quiet(); s.rst = 1'b1;
      s.id_ex_memread = 1'b1; s.id_ex_rd = 5'd7; s.if_id_rs = 10'd7; s.if_id_rs_used = 2'b01;
      s.id_ex_rs = {5'd5, 5'd5}; s.stage_rd = {5'd5, 5'd5}; s.stage_regwrite = 2'b11;
      step(s, ex(4'd0, 0, 0, 0), "reset0");
      step(s, ex(4'd0, 0, 0, 0), "reset1");

      for (int i = 0; i < 10; i++) begin
         s = quiet();
         s.id_ex_rs = {tbl[i].rs2, tbl[i].rs1};
         s.stage_rd = {tbl[i].rd1, tbl[i].rd0};
         s.stage_regwrite = tbl[i].rw;
         s.if_id_rs = {tbl[i].idr2, tbl[i].idr1};
         s.if_id_rs_used = tbl[i].used;
         s.id_ex_rd = tbl[i].exrd;
         s.id_ex_memread = tbl[i].memrd;
         step(s, ex({tbl[i].sel2, tbl[i].sel1}, tbl[i].stall, 0, 0), $sformatf("vec%0d", i));
      end

      // Latency 3 to x9: RAW/WAW stall through BUSY and WB, release after.
      s = quiet(); s.mc_issue = 1'b1; s.mc_rd = 5'd9; s.mc_latency = 4'd3;
      s.if_id_rs = {5'd0, 5'd9}; s.if_id_rs_used = 2'b01;
      step(s, ex(4'd0, 0, 0, 0), "mcA_issue");
      s.mc_issue = 1'b0; s.mc_rd = '0; s.mc_latency = '0;
      step(s, ex(4'd0, 1, 1, 0), "mcA_raw_busy");
      s.if_id_rs_used = 2'b00; s.if_id_regwrite = 1'b1; s.if_id_rd = 5'd9;
      step(s, ex(4'd0, 1, 1, 0), "mcA_waw_busy");
      s.if_id_regwrite = 1'b0; s.if_id_rd = '0; s.if_id_rs = {5'd9, 5'd0}; s.if_id_rs_used = 2'b10;
      step(s, ex(4'd0, 1, 1, 1), "mcA_raw_wb");
      step(s, ex(4'd0, 0, 0, 0), "mcA_release");

      // Back-to-back issue from WB with latency 0; structural stall only while BUSY.
      s = quiet(); s.mc_issue = 1'b1; s.mc_rd = 5'd10; s.mc_latency = 4'd2;
      step(s, ex(4'd0, 0, 0, 0), "mcB_issue");
      s = quiet(); s.if_id_is_mc = 1'b1;
      step(s, ex(4'd0, 1, 1, 0), "mcB_struct");
      s.mc_issue = 1'b1; s.mc_rd = 5'd11; s.mc_latency = 4'd0;
      step(s, ex(4'd0, 0, 1, 1), "mcB_wb_reissue");
      s = quiet(); s.if_id_rs = {5'd0, 5'd11}; s.if_id_rs_used = 2'b01;
      step(s, ex(4'd0, 1, 1, 0), "mcB_busy2");
      s = quiet(); s.if_id_is_mc = 1'b1;
      step(s, ex(4'd0, 0, 1, 1), "mcB_wb2");
      s = quiet();
      step(s, ex(4'd0, 0, 0, 0), "mcB_idle");

      // pend_rd = x0 keeps the unit busy but raises no RAW/WAW.
      s = quiet(); s.mc_issue = 1'b1; s.mc_rd = 5'd0; s.mc_latency = 4'd2;
      step(s, ex(4'd0, 0, 0, 0), "mcC_issue");
      s = quiet(); s.if_id_rs_used = 2'b11; s.if_id_regwrite = 1'b1;
      step(s, ex(4'd0, 0, 1, 0), "mcC_x0_busy");
      step(s, ex(4'd0, 0, 1, 1), "mcC_x0_wb");

      // Load-use and MC RAW together: a single stall cycle.
      s = quiet(); s.mc_issue = 1'b1; s.mc_rd = 5'd12; s.mc_latency = 4'd2;
      step(s, ex(4'd0, 0, 0, 0), "mcD_issue");
      s = quiet(); s.if_id_rs = {5'd0, 5'd12}; s.if_id_rs_used = 2'b01;
      s.id_ex_memread = 1'b1; s.id_ex_rd = 5'd12;
      step(s, ex(4'd0, 1, 1, 0), "mcD_both");
      s = quiet();
      step(s, ex(4'd0, 0, 1, 1), "mcD_wb");
      step(s, ex(4'd0, 0, 0, 0), "mcD_idle");

      // Reset mid-op: abort to IDLE, no writeback, counter cleared.
      s = quiet(); s.mc_issue = 1'b1; s.mc_rd = 5'd13; s.mc_latency = 4'd5;
      step(s, ex(4'd0, 0, 0, 0), "mcE_issue");
      s = quiet(); s.if_id_rs = {5'd0, 5'd13}; s.if_id_rs_used = 2'b01;
      step(s, ex(4'd0, 1, 1, 0), "mcE_busy");
      s.rst = 1'b1;
      step(s, ex(4'd0, 0, 0, 0), "mcE_rst");
      s.rst = 1'b0;
      for (int i = 0; i < 6; i++) step(s, ex(4'd0, 0, 0, 0), $sformatf("mcE_after%0d", i));

      // Stall for 2**4+3 cycles: the 4-bit counter saturates at 4'hF.
      s = quiet(); s.rst = 1'b1;
      step(s, ex(4'd0, 0, 0, 0), "sat_reset");
      s = quiet(); s.id_ex_memread = 1'b1; s.id_ex_rd = 5'd7;
      s.if_id_rs = {5'd0, 5'd7}; s.if_id_rs_used = 2'b01;
      for (int i = 0; i < 19; i++) step(s, ex(4'd0, 1, 0, 0), $sformatf("sat%0d", i));
      s = quiet();
      step(s, ex(4'd0, 0, 0, 0), "sat_hold0");
      step(s, ex(4'd0, 0, 0, 0), "sat_hold1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
